cmd_frontend: RTL and testbench

//  Host-side initiator for the cache controller: accepts one key/value command per valid/ready

---
 rtl/ctrl_types_pkg.sv | 26 ++
 rtl/fe_timeout_ctr.sv | 31 +++
 rtl/cmd_frontend.sv | 117 +++++++++++
 tb/tb_cmd_frontend.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache controller and its host-side command frontend.
// Encodings are fixed because they cross module and host boundaries.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;

  typedef enum logic [1:0] {
    RESP_OK      = 2'd0,
    RESP_MISS    = 2'd1,
    RESP_TIMEOUT = 2'd2,
    RESP_BADOP   = 2'd3
  } resp_status_e;

  typedef enum logic [1:0] {
    FE_IDLE  = 2'd0,
    FE_ISSUE = 2'd1,
    FE_WAIT  = 2'd2,
    FE_RESP  = 2'd3
  } fe_state_e;

endpackage

// File: rtl/fe_timeout_ctr.sv
// Saturating wait-cycle counter. expired_o is high in the enabled cycle whose
// count reaches TIMEOUT_CYCLES (and stays high while saturated).
module fe_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_STEP = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired_o = enable_i && (count_q >= LAST_STEP);

endmodule

// File: rtl/cmd_frontend.sv
// Host-side initiator: accepts one command, pulses it to the controller,
// waits for completion (or timeout) and returns a status/value response.
module cmd_frontend
  import ctrl_types_pkg::*;
#(
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned VALUE_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  operation_e             req_op_i,
  input  logic [KEY_WIDTH-1:0]   req_key_i,
  input  logic [VALUE_WIDTH-1:0] req_value_i,
  output operation_e             ctrl_operation_o,
  output logic [KEY_WIDTH-1:0]   ctrl_key_o,
  output logic [VALUE_WIDTH-1:0] ctrl_value_o,
  input  logic                   ctrl_rdy_i,
  input  logic                   ctrl_op_succ_i,
  input  logic [VALUE_WIDTH-1:0] ctrl_value_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output resp_status_e           resp_status_o,
  output logic [VALUE_WIDTH-1:0] resp_value_o,
  output logic                   busy_o
);

  fe_state_e              state_q, state_d;
  operation_e             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  resp_status_e           status_q, status_d;
  logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
  logic                   expired;

  fe_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == FE_ISSUE),
    .enable_i (state_q == FE_WAIT),
    .expired_o(expired)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    value_d  = value_q;
    status_d = status_q;
    rvalue_d = rvalue_q;
    case (state_q)
      FE_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          key_d   = req_key_i;
          value_d = req_value_i;
          if (req_op_i == NOOP) begin
            status_d = RESP_BADOP;
            rvalue_d = '0;
            state_d  = FE_RESP;
          end else begin
            state_d = FE_ISSUE;
          end
        end
      end
      FE_ISSUE: state_d = FE_WAIT;
      FE_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (ctrl_rdy_i) begin
          status_d = ctrl_op_succ_i ? RESP_OK : RESP_MISS;
          rvalue_d = (op_q == READ && ctrl_op_succ_i) ? ctrl_value_i : '0;
          state_d  = FE_RESP;
        end else if (expired) begin
          status_d = RESP_TIMEOUT;
          rvalue_d = '0;
          state_d  = FE_RESP;
        end
      end
      FE_RESP: begin
        if (resp_ready_i) state_d = FE_IDLE;
      end
      default: state_d = FE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FE_IDLE;
      op_q     <= NOOP;
      key_q    <= '0;
      value_q  <= '0;
      status_q <= RESP_OK;
      rvalue_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      value_q  <= value_d;
      status_q <= status_d;
      rvalue_q <= rvalue_d;
    end
  end

  assign req_ready_o      = (state_q == FE_IDLE);
  assign ctrl_operation_o = (state_q == FE_ISSUE) ? op_q : NOOP;
  assign ctrl_key_o       = key_q;
  assign ctrl_value_o     = value_q;
  assign resp_valid_o     = (state_q == FE_RESP);
  assign resp_status_o    = status_q;
  assign resp_value_o     = rvalue_q;
  assign busy_o           = (state_q != FE_IDLE);

endmodule

// File: tb/tb_cmd_frontend.sv
// Scoreboard bench for cmd_frontend: expected responses are queued when a
// command is driven and compared when resp_valid_o appears.
module tb_cmd_frontend;
  import ctrl_types_pkg::*;

  localparam int unsigned TMO = 4;

  logic         clk = 1'b0;
  logic         rstN = 1'b1;
  logic         reqValid = 1'b0;
  logic         reqReady;
  operation_e   reqOp = NOOP;
  logic [31:0]  reqKey = '0;
  logic [31:0]  reqValue = '0;
  operation_e   ctrlOp;
  logic [31:0]  ctrlKey;
  logic [31:0]  ctrlValueOut;
  logic         ctrlRdy = 1'b0;
  logic         ctrlSucc = 1'b0;
  logic [31:0]  ctrlValueIn = '0;
  logic         respValid;
  logic         respReady = 1'b0;
  resp_status_e respStatus;
  logic [31:0]  respValue;
  logic         busy;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] value;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount = 0;

  cmd_frontend #(
    .KEY_WIDTH(32), .VALUE_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_op_i(reqOp),
    .req_key_i(reqKey), .req_value_i(reqValue),
    .ctrl_operation_o(ctrlOp), .ctrl_key_o(ctrlKey), .ctrl_value_o(ctrlValueOut),
    .ctrl_rdy_i(ctrlRdy), .ctrl_op_succ_i(ctrlSucc), .ctrl_value_i(ctrlValueIn),
    .resp_valid_o(respValid), .resp_ready_i(respReady),
    .resp_status_o(respStatus), .resp_value_o(respValue), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".reqReady"}, 64'(reqReady), 64'd1);
    checkOutput({tag, ".ctrlOp"}, 64'(ctrlOp), 64'(NOOP));
    checkOutput({tag, ".ctrlKey"}, 64'(ctrlKey), 64'd0);
    checkOutput({tag, ".ctrlValue"}, 64'(ctrlValueOut), 64'd0);
    checkOutput({tag, ".respValid"}, 64'(respValid), 64'd0);
    checkOutput({tag, ".respStatus"}, 64'(respStatus), 64'(RESP_OK));
    checkOutput({tag, ".respValue"}, 64'(respValue), 64'd0);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  // One full transaction: delay = WAIT cycle (1-based) carrying rdy, 0 = never.
  task automatic applyStimulus(input operation_e op, input logic [31:0] key,
                               input logic [31:0] val, input int delay,
                               input logic succ, input logic [31:0] rdata,
                               input int hold, input bit staleIssue, input bit lateRdy);
    exp_t e;
    exp_t got;
    int   expLat;
    int   lat;
    if (op == NOOP) begin
      e.status = RESP_BADOP; e.value = '0; expLat = 1;
    end else if (delay == 0 || delay > int'(TMO)) begin
      e.status = RESP_TIMEOUT; e.value = '0; expLat = int'(TMO);
    end else begin
      e.status = succ ? RESP_OK : RESP_MISS;
      e.value  = (op == READ && succ) ? rdata : '0;
      expLat   = delay;
    end
    expQ.push_back(e);

    checkOutput("idleReady", 64'(reqReady), 64'd1);
    reqValid = 1'b1; reqOp = op; reqKey = key; reqValue = val;
    tick();
    reqValid = 1'b0; reqOp = NOOP; reqKey = 32'hFFFF_FFFF; reqValue = 32'hFFFF_FFFF;

    if (op == NOOP) begin
      lat = respValid ? 1 : 0;
      checkOutput("badopOp", 64'(ctrlOp), 64'(NOOP));
    end else begin
      checkOutput("issueOp", 64'(ctrlOp), 64'(op));
      checkOutput("issueKey", 64'(ctrlKey), 64'(key));
      checkOutput("issueReady", 64'(reqReady), 64'd0);
      if (staleIssue) begin
        ctrlRdy = 1'b1; ctrlSucc = 1'b1; ctrlValueIn = 32'hDEAD;
      end
      tick();
      ctrlRdy = 1'b0; ctrlSucc = 1'b0; ctrlValueIn = '0;
      lat = 0;
      for (int w = 1; w <= int'(TMO) + 2; w++) begin
        checkOutput("waitOp", 64'(ctrlOp), 64'(NOOP));
        checkOutput("waitValue", 64'(ctrlValueOut), 64'(val));
        checkOutput("waitBusy", 64'(busy), 64'd1);
        if (w == delay) begin
          ctrlRdy = 1'b1; ctrlSucc = succ; ctrlValueIn = rdata;
        end
        tick();
        ctrlRdy = 1'b0; ctrlSucc = 1'b0; ctrlValueIn = '0;
        if (respValid) begin
          lat = w;
          break;
        end
      end
    end
    checkOutput("respLatency", 64'(lat), 64'(expLat));
    if (lat == 0) return;

    for (int h = 0; h < hold; h++) begin
      reqValid = 1'b1; reqOp = READ;
      if (lateRdy) begin
        ctrlRdy = 1'b1; ctrlSucc = 1'b1; ctrlValueIn = 32'h5A5A;
      end
      tick();
      checkOutput("holdValid", 64'(respValid), 64'd1);
      checkOutput("holdReqReady", 64'(reqReady), 64'd0);
      checkOutput("holdStatus", 64'(respStatus), 64'(e.status));
      checkOutput("holdValue", 64'(respValue), 64'(e.value));
    end
    ctrlRdy = 1'b0; ctrlSucc = 1'b0; ctrlValueIn = '0;

    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 64'd0, 64'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput("respStatus", 64'(respStatus), 64'(got.status));
      checkOutput("respValue", 64'(respValue), 64'(got.value));
    end
    respReady = 1'b1;
    tick();
    respReady = 1'b0; reqValid = 1'b0; reqOp = NOOP;
    checkOutput("postValid", 64'(respValid), 64'd0);
    checkOutput("postBusy", 64'(busy), 64'd0);
    checkOutput("postReady", 64'(reqReady), 64'd1);
    if (lateRdy) begin
      ctrlRdy = 1'b1; ctrlSucc = 1'b1;
      tick();
      ctrlRdy = 1'b0; ctrlSucc = 1'b0;
      checkOutput("lateRdyValid", 64'(respValid), 64'd0);
      checkOutput("lateRdyBusy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    $display("[TB] cmd_frontend bench start");
    #1 rstN = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    tick();
    checkResetOutputs("afterReset");

    applyStimulus(READ,   32'h11, 32'h0,    1, 1'b1, 32'hCAFE, 0, 1'b0, 1'b0);
    applyStimulus(DELETE, 32'h22, 32'h0,    1, 1'b0, 32'h1234, 0, 1'b0, 1'b0);
    applyStimulus(UPSERT, 32'h33, 32'hBEEF, 3, 1'b1, 32'h9999, 0, 1'b0, 1'b0);
    applyStimulus(READ,   32'h34, 32'h0,    2, 1'b0, 32'h4321, 0, 1'b0, 1'b0);
    applyStimulus(READ,   32'h44, 32'h0,    0, 1'b1, 32'h0,    3, 1'b0, 1'b1);
    applyStimulus(UPSERT, 32'h45, 32'h6789, 2, 1'b1, 32'h0,    0, 1'b0, 1'b0);
    applyStimulus(NOOP,   32'h46, 32'h1,    0, 1'b0, 32'h0,    2, 1'b0, 1'b0);
    applyStimulus(READ,   32'h55, 32'h0,    2, 1'b1, 32'h77,  10, 1'b1, 1'b0);
    applyStimulus(READ,   32'h56, 32'h0, int'(TMO), 1'b1, 32'hABCD, 0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      operation_e rop;
      rop = operation_e'($urandom_range(1, 3));
      applyStimulus(rop, $urandom, $urandom, int'($urandom_range(0, TMO)),
                    1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0);
    end

    // Async reset while waiting on the controller, then a stray rdy.
    reqValid = 1'b1; reqOp = READ; reqKey = 32'h66; reqValue = 32'h99;
    tick();
    reqValid = 1'b0;
    tick();
    checkOutput("midWaitBusy", 64'(busy), 64'd1);
    #1 rstN = 1'b0;
    #1 checkResetOutputs("midWaitReset");
    @(negedge clk) rstN = 1'b1;
    tick();
    ctrlRdy = 1'b1; ctrlSucc = 1'b1; ctrlValueIn = 32'hF00D;
    tick();
    ctrlRdy = 1'b0; ctrlSucc = 1'b0; ctrlValueIn = '0;
    checkOutput("strayRdyValid", 64'(respValid), 64'd0);
    checkOutput("strayRdyBusy", 64'(busy), 64'd0);
    tick();
    checkOutput("strayRdyValid2", 64'(respValid), 64'd0);

    applyStimulus(DELETE, 32'h77, 32'h0, 1, 1'b1, 32'h0, 0, 1'b0, 1'b0);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
